// File: rtl/imem_loader.sv
// Byte-stream program loader for the MIPS instruction memory: length, little-endian
// words, XOR checksum. Holds the CPU in reset until a verified image is in place.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN0  = 3'd1;
  localparam logic [2:0] S_LEN1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_CSUM  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  logic [2:0]        state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       shift_q, shift_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       words_left_q, words_left_d;
  logic              xfer;
  logic [15:0]       len_w;

  assign xfer  = in_valid & in_ready_q;
  assign len_w = {in_byte, len_lo_q};

  always_comb begin
    state_d      = state_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    byte_idx_d   = byte_idx_q;
    shift_d      = shift_q;
    csum_d       = csum_q;
    len_lo_d     = len_lo_q;
    words_left_d = words_left_q;

    // The address advances once the strobe cycle has presented it.
    if (imem_we_q) imem_addr_d = imem_addr_q + ADDR_W'(1);

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d     = S_LEN0;
          csum_d      = 8'h00;
          imem_addr_d = '0;
          byte_idx_d  = 2'd0;
        end
      end
      S_LEN0: begin
        if (xfer) begin
          len_lo_d = in_byte;
          state_d  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (xfer) begin
          words_left_d = len_w;
          if (len_w == 16'd0)             state_d = S_CSUM;
          else if ({1'b0, len_w} > CAP)   state_d = S_ERROR;
          else                            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          csum_d     = csum_q ^ in_byte;
          byte_idx_d = byte_idx_q + 2'd1;
          shift_d    = {in_byte, shift_q[23:8]};
          if (byte_idx_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_wdata_d = {in_byte, shift_q};
            words_left_d = words_left_q - 16'd1;
            if (words_left_q == 16'd1) state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (xfer) state_d = (in_byte == csum_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered copies of the next state.
    in_ready_d = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                 (state_d == S_DATA) || (state_d == S_CSUM);
    cpu_rst_d  = (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'h0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      byte_idx_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      done_q       <= done_d;
      err_q        <= err_d;
      byte_idx_q   <= byte_idx_d;
    end
  end

  // Datapath accumulators are cleared by start, so they need no reset.
  always_ff @(posedge clk) begin
    shift_q      <= shift_d;
    csum_q       <= csum_d;
    len_lo_q     <= len_lo_d;
    words_left_q <= words_left_d;
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: a stream builder pushes expected writes,
// a negedge monitor pops and compares every imem_we strobe.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int CAP    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;

  int checks   = 0;
  int failures = 0;

  logic [ADDR_W+31:0] exp_q[$];
  logic [31:0]        img[0:CAP-1];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    logic [ADDR_W+31:0] e;
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", imem_addr, e[ADDR_W+31:32]);
        check("wr_data", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Idle for gap cycles (optionally poking start once), then hand over one byte.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
    bit acc;
    in_valid = 1'b0;
    in_byte  = 8'($urandom);
    for (int g = 0; g < gap; g++) begin
      start = poke && (g == 0);
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_byte  = b;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 40 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL byte_accept_timeout: got in_ready 0 for 40 cycles, expected 1");
    end
  endtask

  // Reference model: stream = count LE16, words LE, XOR of data bytes.
  task automatic run_image(input int n, input bit bad, input int gapmax);
    logic [7:0] cs;
    logic [7:0] b;
    logic [15:0] cnt;
    bit stuck;
    int gap;
    cnt = 16'(n);
    pulse_start();
    check("ready_after_start", in_ready, 1);
    check("busy_cpu_rst", cpu_rst, 1);
    send_byte(cnt[7:0], 0, 1'b0);
    send_byte(cnt[15:8], 0, 1'b0);
    if (n > CAP) begin
      check("oversize_err", err, 1);
      check("oversize_done", done, 0);
      check("oversize_cpu_rst", cpu_rst, 1);
      in_valid = 1'b1;
      in_byte  = 8'($urandom);
      stuck = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (in_ready) stuck = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("oversize_no_accept", stuck, 0);
      return;
    end
    cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({ADDR_W'(i), img[i]});
      for (int k = 0; k < 4; k++) begin
        b   = img[i][8*k +: 8];
        cs  = cs ^ b;
        gap = (gapmax == 0) ? 0 : ((i == 0 && k == 1) ? 3 : int'($urandom_range(0, gapmax)));
        send_byte(b, gap, (gapmax > 0) && (i == 0) && (k == 2));
      end
    end
    if (bad) cs = cs ^ 8'($urandom_range(1, 255));
    send_byte(cs, (gapmax == 0) ? 0 : int'($urandom_range(0, gapmax)), 1'b0);
    check("end_done", done, !bad);
    check("end_err", err, bad);
    check("end_cpu_rst", cpu_rst, bad);
    check("end_ready", in_ready, 0);
    check("writes_drained", exp_q.size(), 0);
  endtask

  task automatic set_nominal();
    img[0] = 32'h2008_0005;
    img[1] = 32'h0000_002A;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation time limit, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_imem_we", imem_we, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_imem_wdata", imem_wdata, 0);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    // Bytes offered while idle must be ignored.
    in_valid = 1'b1;
    in_byte  = 8'h5A;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    check("idle_in_ready", in_ready, 0);

    set_nominal();
    run_image(2, 1'b0, 0);
    run_image(2, 1'b1, 0);
    run_image(2, 1'b0, 0);
    run_image(257, 1'b0, 0);
    run_image(0, 1'b0, 0);
    run_image(0, 1'b1, 0);
    run_image(2, 1'b0, 3);

    // Reset after five data bytes: only the first word may be written.
    img[0] = $urandom;
    img[1] = $urandom;
    pulse_start();
    exp_q.push_back({ADDR_W'(0), img[0]});
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    for (int k = 0; k < 4; k++) send_byte(img[0][8*k +: 8], 0, 1'b0);
    send_byte(img[1][7:0], 0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_cpu_rst", cpu_rst, 1);
    check("midrst_addr", imem_addr, 0);
    check("midrst_done", done, 0);
    in_valid = 1'b1;
    repeat (5) begin in_byte = 8'($urandom); @(posedge clk); #1; end
    in_valid = 1'b0;
    check("midrst_writes", exp_q.size(), 0);
    set_nominal();
    run_image(2, 1'b0, 0);

    for (int i = 0; i < CAP; i++) img[i] = $urandom;
    run_image(CAP, 1'b0, 0);

    repeat (6) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) img[i] = $urandom;
      run_image(n, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
